// File: rtl/alarm_ringer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alarm_ringer: alarm-time match detector with bounded ringing, stop and snooze
// Rev 1.0
// ---------------------------------------------------------------------------
module alarm_ringer #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int CNT_W          = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       alarm_enable,
  input  logic       stop,
  input  logic       snooze,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  input  logic [5:0] alm_hour,
  input  logic [5:0] alm_minute,
  input  logic [5:0] alm_second,
  output logic       ringing,
  output logic       buzzer,
  output logic       snoozing,
  output logic [1:0] snooze_used
);

  localparam logic [CNT_W-1:0] RING_LOAD    = CNT_W'(RING_SECONDS);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD  = CNT_W'(SNOOZE_SECONDS);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [1:0]       SNOOZE_LIMIT = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             beep_q;
  logic [1:0]       used_q;
  logic             ringing_q;
  logic             snoozing_q;
  logic             match_q;

  logic match_d;
  logic trigger_d;

  assign match_d   = alarm_enable &
                     ({cur_hour, cur_minute, cur_second} == {alm_hour, alm_minute, alm_second});
  // Rising edge only, so a held match produces a single alarm event.
  assign trigger_d = match_d & ~match_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      beep_q     <= 1'b0;
      used_q     <= 2'd0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      match_q    <= 1'b1;
    end else begin
      match_q <= match_d;
      if (!alarm_enable) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        beep_q     <= 1'b0;
        used_q     <= 2'd0;
        ringing_q  <= 1'b0;
        snoozing_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (trigger_d) begin
              state_q   <= ST_RINGING;
              ringing_q <= 1'b1;
              cnt_q     <= RING_LOAD;
              beep_q    <= 1'b1;
              used_q    <= 2'd0;
            end
          end
          ST_RINGING: begin
            if (stop) begin
              state_q   <= ST_IDLE;
              ringing_q <= 1'b0;
              cnt_q     <= '0;
              beep_q    <= 1'b0;
              used_q    <= 2'd0;
            end else if (snooze && (used_q < SNOOZE_LIMIT)) begin
              state_q    <= ST_SNOOZE;
              ringing_q  <= 1'b0;
              snoozing_q <= 1'b1;
              cnt_q      <= SNOOZE_LOAD;
              beep_q     <= 1'b0;
              used_q     <= used_q + 2'd1;
            end else if (tick_1hz) begin
              beep_q <= ~beep_q;
              cnt_q  <= cnt_q - CNT_ONE;
              if (cnt_q == CNT_ONE) begin
                state_q   <= ST_IDLE;
                ringing_q <= 1'b0;
              end
            end
          end
          ST_SNOOZE: begin
            if (stop) begin
              state_q    <= ST_IDLE;
              snoozing_q <= 1'b0;
              cnt_q      <= '0;
              used_q     <= 2'd0;
            end else if (tick_1hz) begin
              if (cnt_q == CNT_ONE) begin
                state_q    <= ST_RINGING;
                ringing_q  <= 1'b1;
                snoozing_q <= 1'b0;
                cnt_q      <= RING_LOAD;
                beep_q     <= 1'b1;
              end else begin
                cnt_q <= cnt_q - CNT_ONE;
              end
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            cnt_q      <= '0;
            beep_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ringing     = ringing_q;
  assign buzzer      = ringing_q & beep_q;
  assign snoozing    = snoozing_q;
  assign snooze_used = used_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ringer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alarm_ringer: randomized scenarios checked against a seconds-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alarm_ringer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0, alarm_enable = 1'b1, stop = 1'b0, snooze = 1'b0;
  logic [5:0] cur_hour = '0, cur_minute = '0, cur_second = '0;
  logic [5:0] alm_hour = '0, alm_minute = '0, alm_second = '0;
  logic       ringing, buzzer, snoozing;
  logic [1:0] snooze_used;
  logic [4:0] obs;

  int nrun = 0;
  int nfail = 0;

  alarm_ringer dut (
    .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .alarm_enable(alarm_enable),
    .stop(stop), .snooze(snooze),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .alm_hour(alm_hour), .alm_minute(alm_minute), .alm_second(alm_second),
    .ringing(ringing), .buzzer(buzzer), .snoozing(snoozing), .snooze_used(snooze_used)
  );

  always #5 clock = ~clock;
  assign obs = {ringing, buzzer, snoozing, snooze_used};

  // Reference model: mode 0 = silent, 1 = ringing, 2 = snoozed; seconds left in phase.
  int m_mode = 0, m_left = 0, m_used = 0;
  bit m_beep = 0, m_prev = 1;

  always @(posedge clock) begin
    bit eq, m, trig;
    eq   = (cur_hour == alm_hour) && (cur_minute == alm_minute) && (cur_second == alm_second);
    m    = alarm_enable && eq;
    trig = m && !m_prev;
    if (reset) begin
      m_mode = 0; m_left = 0; m_used = 0; m_beep = 0; m_prev = 1;
    end else begin
      m_prev = m;
      if (!alarm_enable) begin
        m_mode = 0; m_used = 0; m_beep = 0;
      end else if (m_mode != 0 && stop) begin
        m_mode = 0; m_used = 0; m_beep = 0;
      end else if (m_mode == 1 && snooze && m_used < 3) begin
        m_mode = 2; m_left = 300; m_used++;
      end else if (m_mode == 0 && trig) begin
        m_mode = 1; m_left = 60; m_beep = 1; m_used = 0;
      end else if (m_mode != 0 && tick_1hz) begin
        m_left--;
        if (m_mode == 1) begin
          m_beep = !m_beep;
          if (m_left == 0) m_mode = 0;
        end else if (m_left == 0) begin
          m_mode = 1; m_left = 60; m_beep = 1;
        end
      end
    end
  end

  function automatic logic [4:0] model_vec();
    return {m_mode == 1, (m_mode == 1) && m_beep, m_mode == 2, 2'(m_used)};
  endfunction

  task automatic cyc(input bit tk, input bit st, input bit sn);
    tick_1hz = tk; stop = st; snooze = sn;
    @(posedge clock); #1;
    tick_1hz = 0; stop = 0; snooze = 0;
  endtask

  task automatic trigger_alarm();
    alm_hour = 7; alm_minute = 30; alm_second = 0;
    cur_hour = 7; cur_minute = 29; cur_second = 59;
    cyc(0, 0, 0);
    cur_minute = 30; cur_second = 0;
    cyc(0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1; alarm_enable = 1;
    cyc(0, 0, 0); cyc(0, 0, 0);
    nrun++;
    if (obs !== 5'b0) begin nfail++; $display("FAIL reset_state got=%b exp=%b", obs, 5'b0); end
    reset = 0;
    repeat (5) begin
      cyc(0, 0, 0);
      nrun++;
      if (obs !== 5'b0) begin nfail++; $display("FAIL reset_release_no_ring got=%b exp=%b", obs, 5'b0); end
    end
  endtask

  task automatic test_ring_basic();
    int n;
    alm_hour = 7; alm_minute = 30; alm_second = 0;
    cur_hour = 7; cur_minute = 29; cur_second = 59;
    cyc(0, 0, 0);
    nrun++;
    if (obs !== 5'b0) begin nfail++; $display("FAIL pre_match got=%b exp=%b", obs, 5'b0); end
    cur_minute = 30; cur_second = 0;
    cyc(0, 0, 0);
    nrun++;
    if (obs !== 5'b11000) begin nfail++; $display("FAIL trigger got=%b exp=%b", obs, 5'b11000); end
    cyc(1, 0, 0);
    nrun++;
    if (obs !== 5'b10000) begin nfail++; $display("FAIL beep_off got=%b exp=%b", obs, 5'b10000); end
    cyc(1, 0, 0);
    nrun++;
    if (obs !== 5'b11000) begin nfail++; $display("FAIL beep_on got=%b exp=%b", obs, 5'b11000); end
    n = 2;
    while (ringing === 1'b1 && n < 100) begin
      repeat ($urandom_range(0, 2)) begin
        cyc(0, 0, 0);
        nrun++;
        if (obs !== model_vec()) begin nfail++; $display("FAIL ring_idle got=%b exp=%b", obs, model_vec()); end
      end
      cyc(1, 0, 0); n++;
      nrun++;
      if (obs !== model_vec()) begin nfail++; $display("FAIL ring_tick got=%b exp=%b", obs, model_vec()); end
    end
    nrun++;
    if (n != 60) begin nfail++; $display("FAIL auto_stop_ticks got=%0d exp=%0d", n, 60); end
    repeat (10) begin
      cyc(1, 0, 0);
      nrun++;
      if (obs[4:2] !== 3'b000) begin nfail++; $display("FAIL no_rering got=%b exp=%b", obs[4:2], 3'b000); end
    end
  endtask

  task automatic test_snooze();
    int n;
    trigger_alarm();
    for (int k = 1; k <= 3; k++) begin
      repeat ($urandom_range(1, 3)) cyc(1, 0, 0);
      cyc(k == 1, 0, 1);
      nrun++;
      if (obs !== {3'b001, 2'(k)}) begin nfail++; $display("FAIL snooze_enter got=%b exp=%b", obs, {3'b001, 2'(k)}); end
      n = 0;
      while (snoozing === 1'b1 && n < 400) begin
        if ($urandom_range(0, 3) == 0) cyc(0, 0, 1);
        cyc(1, 0, 0); n++;
        nrun++;
        if (obs !== model_vec()) begin nfail++; $display("FAIL snooze_run got=%b exp=%b", obs, model_vec()); end
      end
      nrun++;
      if (n != 300 || ringing !== 1'b1) begin
        nfail++; $display("FAIL snooze_len got=%0d ring=%b exp=%0d ring=1", n, ringing, 300);
      end
    end
    cyc(0, 0, 1);
    nrun++;
    if (obs !== 5'b11011) begin nfail++; $display("FAIL snooze_limit got=%b exp=%b", obs, 5'b11011); end
    cyc(0, 1, 0);
    nrun++;
    if (obs !== 5'b0) begin nfail++; $display("FAIL stop_after_limit got=%b exp=%b", obs, 5'b0); end
  endtask

  task automatic test_stop_snooze();
    trigger_alarm();
    cyc(1, 0, 0);
    cyc(1, 1, 1);
    nrun++;
    if (obs !== 5'b0) begin nfail++; $display("FAIL stop_wins got=%b exp=%b", obs, 5'b0); end
    cyc(1, 1, 1);
    nrun++;
    if (obs !== 5'b0) begin nfail++; $display("FAIL idle_pulses got=%b exp=%b", obs, 5'b0); end
  endtask

  task automatic test_disable();
    trigger_alarm();
    cur_second = 5;
    repeat (3) cyc(1, 0, 0);
    alarm_enable = 0;
    cyc(0, 0, 0);
    nrun++;
    if (obs !== 5'b0) begin nfail++; $display("FAIL disable_ring got=%b exp=%b", obs, 5'b0); end
    alarm_enable = 1;
    repeat (4) begin
      cyc(1, 0, 0);
      nrun++;
      if (obs !== 5'b0) begin nfail++; $display("FAIL reenable_ring got=%b exp=%b", obs, 5'b0); end
    end
    trigger_alarm();
    cyc(0, 0, 1);
    cur_second = 7;
    repeat (5) cyc(1, 0, 0);
    nrun++;
    if (obs !== 5'b00101) begin nfail++; $display("FAIL snooze_before_disable got=%b exp=%b", obs, 5'b00101); end
    alarm_enable = 0;
    cyc(1, 0, 0);
    nrun++;
    if (obs !== 5'b0) begin nfail++; $display("FAIL disable_snooze got=%b exp=%b", obs, 5'b0); end
    alarm_enable = 1;
    repeat (4) begin
      cyc(1, 0, 0);
      nrun++;
      if (obs !== 5'b0) begin nfail++; $display("FAIL reenable_snooze got=%b exp=%b", obs, 5'b0); end
    end
  endtask

  task automatic test_reset_mid();
    trigger_alarm();
    cyc(1, 0, 0);
    reset = 1;
    cyc(0, 0, 0);
    nrun++;
    if (obs !== 5'b0) begin nfail++; $display("FAIL reset_mid got=%b exp=%b", obs, 5'b0); end
    reset = 0;
    cyc(0, 0, 0);
    nrun++;
    if (obs !== 5'b0) begin nfail++; $display("FAIL reset_mid_release got=%b exp=%b", obs, 5'b0); end
  endtask

  task automatic test_random();
    alm_hour = 0; alm_minute = 0; alm_second = 5;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) cur_second = 6'($urandom_range(4, 6));
      if ($urandom_range(0, 399) == 0) alm_second = 6'($urandom_range(4, 6));
      alarm_enable = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0);
      nrun++;
      if (obs !== model_vec()) begin nfail++; $display("FAIL random got=%b exp=%b cyc=%0d", obs, model_vec(), i); end
    end
  endtask

  initial begin
    test_reset();
    test_ring_basic();
    test_snooze();
    test_stop_snooze();
    test_disable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
`default_nettype wire
